// File: rtl/normal_op_loader.sv
// normal_op_loader
// ----------------------------------------------------------------------------
// Purpose:
//   Loads one complete set of per-transducer duty/phase words from a BRAM and
//   publishes it to the silent LPF as a single atomic update. A load request
//   (START) walks BRAM_ADDR over 0..TRANS_NUM-1. Each returned word is captured
//   into a shadow array. When every entry has been captured, the whole shadow
//   set is copied to DUTY/PHASE in one edge. UPDATE then pulses for one cycle.
//   START seen while a load is in progress is remembered as a single pending
//   request, and that request starts the next load straight after NOTIFY.
//
// Optional feature (macro LOADER_SKIP_UNCHANGED_EN):
//   Each captured word is compared with the DUTY/PHASE entry currently being
//   output. UPDATE is raised only if at least one entry differs. The state
//   sequence and its timing do not change.
//
// Ports:
//   CLK        in   sole clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   START      in   load request, level sampled on every edge
//   BRAM_ADDR  out  transducer read address
//   BRAM_DATA  in   read word, {duty, phase}, valid BRAM_LATENCY cycles after
//                   the address is presented
//   DUTY       out  committed duty array (entry k = DUTY[k])
//   PHASE      out  committed phase array (entry k = PHASE[k])
//   UPDATE     out  one-cycle pulse: DUTY/PHASE hold a new complete set
//   BUSY       out  high whenever the controller is not idle
// ----------------------------------------------------------------------------
module normal_op_loader #(
  parameter int TRANS_NUM    = 249,
  parameter int WIDTH        = 8,
  parameter int BRAM_LATENCY = 2,
  localparam int ADDR_W      = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              START,
  output logic [ADDR_W-1:0]                 BRAM_ADDR,
  input  logic [2*WIDTH-1:0]                BRAM_DATA,
  output logic [TRANS_NUM-1:0][WIDTH-1:0]   DUTY,
  output logic [TRANS_NUM-1:0][WIDTH-1:0]   PHASE,
  output logic                              UPDATE,
  output logic                              BUSY
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TRANS_NUM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    NOTIFY = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic              pending;
  logic              issue_done;
  logic              issue;
  logic              enter_load;
  logic              cap_vld;
  logic [ADDR_W-1:0] cap_idx;
  logic              all_captured;

  logic [TRANS_NUM-1:0][WIDTH-1:0] shadow_duty;
  logic [TRANS_NUM-1:0][WIDTH-1:0] shadow_phase;

  // A read is issued on every LOAD cycle until the last address has gone out.
  // After that the address holds while the remaining words drain back.
  assign issue      = (state == LOAD) && !issue_done;
  assign enter_load = (next_state == LOAD) && (state != LOAD);
  assign BUSY       = (state != IDLE);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  // LOAD waits for the flag that marks the last entry as captured, so that the
  // copy on leaving LOAD always sees a complete shadow set. NOTIFY goes
  // straight back to LOAD on a pending request or on a START seen during
  // NOTIFY itself. A held START therefore gives back-to-back loads with no
  // IDLE cycle in between.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (START) next_state = LOAD;
      LOAD:    if (all_captured) next_state = COMMIT;
      COMMIT:  next_state = NOTIFY;
      NOTIFY:  next_state = (pending || START) ? LOAD : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Address generator. Restarts at 0 on every entry to LOAD. It steps once
  // per issued read, holds on the last address, and returns to 0 when the
  // controller goes idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BRAM_ADDR  <= '0;
      issue_done <= 1'b0;
    end else if (enter_load) begin
      BRAM_ADDR  <= '0;
      issue_done <= 1'b0;
    end else if (issue) begin
      if (BRAM_ADDR == LAST_ADDR) begin
        issue_done <= 1'b1;
      end else begin
        BRAM_ADDR <= BRAM_ADDR + ADDR_W'(1);
      end
    end else if (next_state == IDLE) begin
      BRAM_ADDR <= '0;
    end
  end

  // Pending request: any START while busy collapses into one flag. Leaving
  // NOTIFY always consumes it, because NOTIFY has already acted on it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending <= 1'b0;
    end else if (state == NOTIFY) begin
      pending <= 1'b0;
    end else if ((state != IDLE) && START) begin
      pending <= 1'b1;
    end
  end

  // Issue-aligned tag pipeline. Each issued read carries its own index. The
  // index travels with the read so that the word arriving BRAM_LATENCY edges
  // later lands in the matching shadow entry.
  if (BRAM_LATENCY <= 1) begin : g_direct
    assign cap_vld = issue;
    assign cap_idx = BRAM_ADDR;
  end else begin : g_pipe
    logic [BRAM_LATENCY-2:0] pipe_vld;
    logic [ADDR_W-1:0]       pipe_idx [BRAM_LATENCY-1];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        pipe_vld <= '0;
        for (int j = 0; j < BRAM_LATENCY - 1; j++) begin
          pipe_idx[j] <= '0;
        end
      end else begin
        pipe_vld[0] <= issue;
        pipe_idx[0] <= BRAM_ADDR;
        for (int j = 1; j < BRAM_LATENCY - 1; j++) begin
          pipe_vld[j] <= pipe_vld[j-1];
          pipe_idx[j] <= pipe_idx[j-1];
        end
      end
    end

    assign cap_vld = pipe_vld[BRAM_LATENCY-2];
    assign cap_idx = pipe_idx[BRAM_LATENCY-2];
  end

  // Shadow capture. The contents matter only once a load has completed, so
  // this array needs no reset.
  always_ff @(posedge CLK) begin
    if (cap_vld) begin
      shadow_duty[cap_idx]  <= BRAM_DATA[2*WIDTH-1:WIDTH];
      shadow_phase[cap_idx] <= BRAM_DATA[WIDTH-1:0];
    end
  end

  // Marks the edge that captured the final entry. LOAD hands over to COMMIT
  // on the following edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      all_captured <= 1'b0;
    end else begin
      all_captured <= cap_vld && (cap_idx == LAST_ADDR);
    end
  end

  // Atomic publish. The whole shadow set is copied in the single edge that
  // moves LOAD to COMMIT. No partially loaded set is ever visible.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DUTY  <= '0;
      PHASE <= '0;
    end else if ((state == LOAD) && all_captured) begin
      DUTY  <= shadow_duty;
      PHASE <= shadow_phase;
    end
  end

`ifdef LOADER_SKIP_UNCHANGED_EN
  logic changed;

  // Records whether any captured word differs from the set being output.
  // DUTY/PHASE are frozen for the whole load, so each word is compared with
  // the value it would replace.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      changed <= 1'b0;
    end else if (enter_load) begin
      changed <= 1'b0;
    end else if (cap_vld &&
                 (BRAM_DATA != {DUTY[cap_idx], PHASE[cap_idx]})) begin
      changed <= 1'b1;
    end
  end

  // The UPDATE pulse covers the NOTIFY cycle, and only when content changed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      UPDATE <= 1'b0;
    end else begin
      UPDATE <= (next_state == NOTIFY) && changed;
    end
  end
`else
  // The UPDATE pulse covers exactly the NOTIFY cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      UPDATE <= 1'b0;
    end else begin
      UPDATE <= (next_state == NOTIFY);
    end
  end
`endif

endmodule

// File: doc/normal_op_loader.md
NORMAL_OP_LOADER -- requirements
Module: normal_op_loader

Interface
REQ-001 Parameter TRANS_NUM, default 249: number of transducers, i.e. BRAM entries per load.
REQ-002 Parameter WIDTH, default 8: duty/phase bit width.
REQ-003 Parameter BRAM_LATENCY, default 2: cycles from BRAM_ADDR presented to BRAM_DATA valid (>=1).
REQ-004 CLK  in  1  sole clock; all logic on rising edge.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 START  in  1  load request; level sampled every edge.
REQ-007 BRAM_ADDR  out  clog2(TRANS_NUM)  transducer read address.
REQ-008 BRAM_DATA  in  2*WIDTH  read word: [2*WIDTH-1:WIDTH]=duty, [WIDTH-1:0]=phase.
REQ-009 DUTY  out  WIDTH x TRANS_NUM  committed duty array; feeds the silent LPF DUTY input.
REQ-010 PHASE  out  WIDTH x TRANS_NUM  committed phase array; feeds the silent LPF PHASE input.
REQ-011 UPDATE  out  1  one-cycle pulse: DUTY/PHASE hold a new complete set.
REQ-012 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-013 The block SHALL implement states IDLE, LOAD, COMMIT, NOTIFY.
REQ-014 In IDLE, START=1 at edge E0 SHALL move to LOAD with BRAM_ADDR=0.
REQ-015 In LOAD, BRAM_ADDR SHALL increment by 1 per cycle up to TRANS_NUM-1 and then hold.
REQ-016 The word for address k SHALL be captured into shadow entry k at edge E0+k+BRAM_LATENCY, tracked by an issue-aligned delay pipeline, not by a second free-running guess.
REQ-017 After the capture of entry TRANS_NUM-1 (edge E0+TRANS_NUM-1+BRAM_LATENCY), the state SHALL be COMMIT.
REQ-018 COMMIT SHALL copy all shadow entries to DUTY/PHASE in one edge (E0+TRANS_NUM+BRAM_LATENCY); DUTY/PHASE SHALL never show a partially loaded set.
REQ-019 NOTIFY SHALL follow COMMIT; UPDATE SHALL be high for exactly the cycle after edge E0+TRANS_NUM+BRAM_LATENCY+1 and low otherwise.
REQ-020 DUTY/PHASE SHALL remain constant from COMMIT until the next COMMIT.
REQ-021 START=1 while not in IDLE (including the NOTIFY cycle) SHALL set a single pending flag; multiple requests SHALL collapse into one.
REQ-022 From NOTIFY, a set pending flag SHALL clear it and enter LOAD with BRAM_ADDR=0; otherwise the next state SHALL be IDLE.
REQ-023 START held continuously SHALL produce back-to-back loads, one UPDATE per TRANS_NUM+BRAM_LATENCY+2 cycles.
REQ-024 BRAM_ADDR SHALL be 0 in IDLE.

Reset
REQ-025 RST_N low SHALL immediately force IDLE, BRAM_ADDR=0, UPDATE=0, BUSY=0, pending=0, and all DUTY/PHASE entries to 0, independent of CLK.
REQ-026 Reset mid-LOAD SHALL abandon the load: no COMMIT and no UPDATE; shadow contents are don't-care.
REQ-027 The first START after RST_N rises SHALL be honoured on the first edge with RST_N high.

Configuration
REQ-028 Macro LOADER_SKIP_UNCHANGED_EN, when defined: each captured word SHALL be compared with the current DUTY/PHASE entry, and a changed flag (cleared on entering LOAD) SHALL be set on any mismatch.
REQ-029 With the macro defined, NOTIFY SHALL assert UPDATE only if the changed flag is set; COMMIT, state sequence and timing SHALL be unchanged.
REQ-030 With the macro undefined, no compare logic SHALL exist and every NOTIFY SHALL assert UPDATE.

Verification
REQ-031 TRANS_NUM=4, BRAM_LATENCY=2, BRAM[k]={8'h10+k, 8'h20+k}, START pulse at E0 -> BRAM_ADDR 0,1,2,3 on E0..E0+3; DUTY={10,11,12,13}, PHASE={20,21,22,23} at E0+6; UPDATE high one cycle from E0+7; BUSY low after E0+8.
REQ-032 Same setup, START re-pulsed at E0+3 and E0+5 -> a single second load with BRAM_ADDR=0 at E0+8; exactly two UPDATE pulses total.
REQ-033 Change BRAM mid-load at address 2 before its read -> committed set is entirely old entries 0-1 plus new entries 2-3; no intermediate DUTY value is ever visible.
REQ-034 RST_N low at E0+4 -> all outputs 0 immediately; no UPDATE; START at a later edge gives a normal load with UPDATE 7 cycles later.
REQ-035 LOADER_SKIP_UNCHANGED_EN defined, BRAM all zero after reset -> load completes, BUSY sequence identical, UPDATE stays 0; then set BRAM[3]={8'h01, 8'h00} -> UPDATE pulses once.
REQ-036 START held high for 30 cycles, TRANS_NUM=4 -> UPDATE pulses every 8 cycles, with no IDLE cycle between loads.
